// File: rtl/ex_alu_ccr_pkg.sv
// Shared definitions for the execute-stage ALU and its condition-code register.
// Holds the ALU opcode map, CCR bit positions and the ALU-B operand select codes
// that the operand mux and the ALU decode agree on.
package ex_alu_ccr_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned OPW_DEF = 4;
  localparam int unsigned CCRW    = 4;
  localparam int unsigned BSELW   = 2;

  // ALU opcodes; unlisted codes decode as NOP
  localparam logic [OPW_DEF-1:0] OP_NOP  = 4'd0;
  localparam logic [OPW_DEF-1:0] OP_ADD  = 4'd1;
  localparam logic [OPW_DEF-1:0] OP_SUB  = 4'd2;
  localparam logic [OPW_DEF-1:0] OP_AND  = 4'd3;
  localparam logic [OPW_DEF-1:0] OP_OR   = 4'd4;
  localparam logic [OPW_DEF-1:0] OP_NOT  = 4'd5;
  localparam logic [OPW_DEF-1:0] OP_NEG  = 4'd6;
  localparam logic [OPW_DEF-1:0] OP_INC  = 4'd7;
  localparam logic [OPW_DEF-1:0] OP_DEC  = 4'd8;
  localparam logic [OPW_DEF-1:0] OP_RLC  = 4'd9;
  localparam logic [OPW_DEF-1:0] OP_RRC  = 4'd10;
  localparam logic [OPW_DEF-1:0] OP_SETC = 4'd11;
  localparam logic [OPW_DEF-1:0] OP_CLRC = 4'd12;
  localparam logic [OPW_DEF-1:0] OP_MOV  = 4'd13;

  // CCR bit positions: ccr = {V, C, N, Z}
  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_V = 3;

  // ALU-B operand select codes used by the upstream operand mux
  localparam logic [BSELW-1:0] BSEL_RB  = 2'd0;
  localparam logic [BSELW-1:0] BSEL_IMM = 2'd1;
  localparam logic [BSELW-1:0] BSEL_RA  = 2'd2;

  // Merge freshly computed flags into the current CCR under a write mask
  function automatic logic [CCRW-1:0] merge_flags(input logic [CCRW-1:0] cur,
                                                  input logic [CCRW-1:0] nxt,
                                                  input logic [CCRW-1:0] mask);
    merge_flags = (cur & ~mask) | (nxt & mask);
  endfunction

endpackage

// File: rtl/ex_alu_ccr_alu_core.sv
// Combinational ALU core.
// Ports:
//   alu_op    opcode from ID/EX
//   a, b      operands (b is the ALU-B mux output)
//   carry_in  registered C flag, used by RLC/RRC
//   result_c  DW-bit result
//   flags_c   candidate {V,C,N,Z}
//   mask_c    which CCR bits this opcode writes
module ex_alu_ccr_alu_core
  import ex_alu_ccr_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            carry_in,
  output logic [DW-1:0]   result_c,
  output logic [CCRW-1:0] flags_c,
  output logic [CCRW-1:0] mask_c
);

  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          sub;
  logic [DW:0]   sum;
  logic          arith_c;
  logic          arith_v;

  // Arithmetic operand selection: INC/DEC/NEG reuse the ADD/SUB datapath
  always_comb begin
    x   = a;
    y   = b;
    sub = 1'b0;
    unique case (alu_op)
      OP_SUB:  sub = 1'b1;
      OP_INC:  begin x = b;  y = DW'(1); end
      OP_DEC:  begin x = b;  y = DW'(1); sub = 1'b1; end
      OP_NEG:  begin x = '0; y = b;      sub = 1'b1; end
      default: ;
    endcase
  end

  // One extra bit carries out of an add, or signals a borrow on a subtract
  assign sum     = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  assign arith_c = sum[DW];
  assign arith_v = sub ? ((x[DW-1] != y[DW-1]) && (sum[DW-1] != x[DW-1]))
                       : ((x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1]));

  // Result and flag generation
  always_comb begin
    result_c = '0;
    flags_c  = '0;
    mask_c   = '0;
    unique case (alu_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
        result_c       = sum[DW-1:0];
        flags_c[CCR_C] = arith_c;
        flags_c[CCR_V] = arith_v;
        mask_c         = 4'b1111;
      end
      OP_AND: begin result_c = a & b; mask_c = 4'b0011; end
      OP_OR:  begin result_c = a | b; mask_c = 4'b0011; end
      OP_NOT: begin result_c = ~b;    mask_c = 4'b0011; end
      OP_RLC: begin
        result_c       = {b[DW-2:0], carry_in};
        flags_c[CCR_C] = b[DW-1];
        mask_c         = 4'b0111;
      end
      OP_RRC: begin
        result_c       = {carry_in, b[DW-1:1]};
        flags_c[CCR_C] = b[0];
        mask_c         = 4'b0111;
      end
      OP_SETC: begin result_c = b; flags_c[CCR_C] = 1'b1; mask_c = 4'b0100; end
      OP_CLRC: begin result_c = b; flags_c[CCR_C] = 1'b0; mask_c = 4'b0100; end
      OP_MOV:  result_c = b;
      default: result_c = '0;
    endcase
    // Z and N always come from the DW-bit result; the mask decides if they land
    flags_c[CCR_Z] = (result_c == '0);
    flags_c[CCR_N] = result_c[DW-1];
  end

endmodule

// File: rtl/ex_alu_ccr.sv
// Execute-stage ALU with condition-code register, shadow CCR and a registered
// EX/MEM result (1-cycle latency).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op_valid, alu_op      ID/EX slot valid and opcode
//   op_a, op_b            operands (ra, ALU-B mux output)
//   stall, flush          hold everything / kill incoming slot
//   int_save, rti_restore CCR -> shadow snapshot / shadow -> CCR restore
//   alu_result            registered result
//   result_valid          registered valid
//   ccr                   registered {V,C,N,Z}
module ex_alu_ccr
  import ex_alu_ccr_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   op_a,
  input  logic [DW-1:0]   op_b,
  input  logic            stall,
  input  logic            flush,
  input  logic            int_save,
  input  logic            rti_restore,
  output logic [DW-1:0]   alu_result,
  output logic            result_valid,
  output logic [CCRW-1:0] ccr
);

  logic [DW-1:0]   core_result;
  logic [CCRW-1:0] core_flags;
  logic [CCRW-1:0] core_mask;

  logic            accept;
  logic            update;
  logic [CCRW-1:0] post_ccr;
  logic [CCRW-1:0] shadow;
  logic [DW-1:0]   result_nxt;
  logic            valid_nxt;
  logic [CCRW-1:0] ccr_nxt;
  logic [CCRW-1:0] shadow_nxt;

  ex_alu_ccr_alu_core #(
    .DW  (DW),
    .OPW (OPW)
  ) u_core (
    .alu_op   (alu_op),
    .a        (op_a),
    .b        (op_b),
    .carry_in (ccr[CCR_C]),
    .result_c (core_result),
    .flags_c  (core_flags),
    .mask_c   (core_mask)
  );

  // Priority: flush overrides stall, so a flushed slot still advances state
  always_comb begin
    result_nxt = alu_result;
    valid_nxt  = result_valid;
    ccr_nxt    = ccr;
    shadow_nxt = shadow;
    accept     = op_valid & ~stall & ~flush;
    update     = flush | ~stall;
    post_ccr   = accept ? merge_flags(ccr, core_flags, core_mask) : ccr;
    if (update) begin
      valid_nxt = accept;
      if (accept) begin
        result_nxt = core_result;
      end
      // Restore beats the op's flags; the snapshot always sees post-op flags
      ccr_nxt    = rti_restore ? shadow : post_ccr;
      shadow_nxt = int_save ? post_ccr : shadow;
    end
  end

  // EX/MEM, CCR and shadow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result   <= '0;
      result_valid <= 1'b0;
      ccr          <= '0;
      shadow       <= '0;
    end else begin
      alu_result   <= result_nxt;
      result_valid <= valid_nxt;
      ccr          <= ccr_nxt;
      shadow       <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_ex_alu_ccr.sv
// Directed bench for ex_alu_ccr: each step queues its hand-computed expected
// registered outputs; a monitor pops and compares one entry after each edge.
module tb_ex_alu_ccr;
  import ex_alu_ccr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [3:0] alu_op = 4'd0;
  logic [7:0] op_a = 8'd0;
  logic [7:0] op_b = 8'd0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       int_save = 1'b0;
  logic       rti_restore = 1'b0;
  logic [7:0] alu_result;
  logic       result_valid;
  logic [3:0] ccr;

  typedef struct packed {
    logic [7:0] res;
    logic       val;
    logic [3:0] ccr;
    logic [7:0] id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  ex_alu_ccr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .alu_op       (alu_op),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .flush        (flush),
    .int_save     (int_save),
    .rti_restore  (rti_restore),
    .alu_result   (alu_result),
    .result_valid (result_valid),
    .ccr          (ccr)
  );

  // Monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (result_valid !== e.val) begin
        errors++;
        $display("FAIL step%0d result_valid: got %b expected %b", e.id, result_valid, e.val);
      end
      checks++;
      if (alu_result !== e.res) begin
        errors++;
        $display("FAIL step%0d alu_result: got %02h expected %02h", e.id, alu_result, e.res);
      end
      checks++;
      if (ccr !== e.ccr) begin
        errors++;
        $display("FAIL step%0d ccr: got %04b expected %04b", e.id, ccr, e.ccr);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic st, input logic fl, input logic sv, input logic rt,
                      input logic [7:0] er, input logic ev, input logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    rst_n       = r;
    op_valid    = v;
    alu_op      = op;
    op_a        = a;
    op_b        = b;
    stall       = st;
    flush       = fl;
    int_save    = sv;
    rti_restore = rt;
    step_no++;
    e.res = er;
    e.val = ev;
    e.ccr = ec;
    e.id  = 8'(step_no);
    q.push_back(e);
  endtask

  initial begin
    //   rst v  op       a      b      st fl sv rt   res    val ccr{VCNZ}
    step(0, 1, OP_ADD,  8'h12, 8'h34, 0, 0, 0, 0,  8'h00, 0, 4'b0000);
    step(1, 1, OP_ADD,  8'h12, 8'h34, 0, 0, 0, 0,  8'h46, 1, 4'b0000);
    step(1, 1, OP_ADD,  8'h7F, 8'h01, 0, 0, 0, 0,  8'h80, 1, 4'b1010);
    step(1, 1, OP_ADD,  8'hFF, 8'h01, 0, 0, 0, 0,  8'h00, 1, 4'b0101);
    step(1, 1, OP_SUB,  8'h03, 8'h05, 0, 0, 0, 0,  8'hFE, 1, 4'b0110);
    step(1, 1, OP_INC,  8'h00, 8'h7F, 0, 0, 0, 0,  8'h80, 1, 4'b1010);
    step(1, 1, OP_DEC,  8'h00, 8'h00, 0, 0, 0, 0,  8'hFF, 1, 4'b0110);
    step(1, 1, OP_NEG,  8'h00, 8'h01, 0, 0, 0, 0,  8'hFF, 1, 4'b0110);
    step(1, 1, OP_CLRC, 8'h00, 8'h33, 0, 0, 0, 0,  8'h33, 1, 4'b0010);
    step(1, 1, OP_SETC, 8'h00, 8'h55, 0, 0, 0, 0,  8'h55, 1, 4'b0110);
    step(1, 1, OP_RLC,  8'h00, 8'h80, 0, 0, 0, 0,  8'h01, 1, 4'b0100);
    step(1, 1, OP_RRC,  8'h00, 8'h01, 0, 0, 0, 0,  8'h80, 1, 4'b0110);
    step(1, 1, OP_RRC,  8'h00, 8'h00, 0, 0, 0, 0,  8'h80, 1, 4'b0010);
    step(1, 1, OP_AND,  8'hF0, 8'h0F, 0, 0, 0, 0,  8'h00, 1, 4'b0001);
    step(1, 1, OP_OR,   8'h80, 8'h01, 0, 0, 0, 0,  8'h81, 1, 4'b0010);
    step(1, 1, OP_NOT,  8'h00, 8'hFF, 0, 0, 0, 0,  8'h00, 1, 4'b0001);
    step(1, 1, OP_MOV,  8'h00, 8'hA5, 0, 0, 0, 0,  8'hA5, 1, 4'b0001);
    // stall freezes everything, including an int_save request
    step(1, 1, OP_ADD,  8'h80, 8'h80, 0, 0, 0, 0,  8'h00, 1, 4'b1101);
    step(1, 1, OP_ADD,  8'h01, 8'h01, 1, 0, 0, 0,  8'h00, 1, 4'b1101);
    step(1, 1, OP_ADD,  8'h01, 8'h01, 1, 0, 1, 0,  8'h00, 1, 4'b1101);
    step(1, 1, OP_ADD,  8'h01, 8'h01, 1, 0, 0, 0,  8'h00, 1, 4'b1101);
    step(1, 1, OP_ADD,  8'h01, 8'h01, 1, 1, 0, 0,  8'h00, 0, 4'b1101);
    step(1, 0, OP_ADD,  8'h01, 8'h01, 0, 0, 0, 0,  8'h00, 0, 4'b1101);
    // shadow still holds its reset value
    step(1, 0, OP_NOP,  8'h00, 8'h00, 0, 0, 0, 1,  8'h00, 0, 4'b0000);
    // interrupt save / restore
    step(1, 1, OP_ADD,  8'hFF, 8'h01, 0, 0, 0, 0,  8'h00, 1, 4'b0101);
    step(1, 1, OP_AND,  8'h0F, 8'hFF, 0, 0, 1, 0,  8'h0F, 1, 4'b0100);
    step(1, 1, OP_CLRC, 8'h00, 8'h00, 0, 0, 0, 0,  8'h00, 1, 4'b0000);
    step(1, 1, OP_SETC, 8'h00, 8'h11, 0, 0, 0, 1,  8'h11, 1, 4'b0100);
    step(1, 1, OP_ADD,  8'h7F, 8'h01, 0, 0, 1, 1,  8'h80, 1, 4'b0100);
    step(1, 1, OP_NOP,  8'h12, 8'h34, 0, 0, 0, 1,  8'h00, 1, 4'b1010);
    step(1, 1, 4'hF,    8'h12, 8'h34, 0, 0, 0, 0,  8'h00, 1, 4'b1010);
    // mid-stream reset clears shadow too
    step(0, 1, OP_ADD,  8'h12, 8'h34, 0, 0, 1, 1,  8'h00, 0, 4'b0000);
    step(1, 0, OP_NOP,  8'h00, 8'h00, 0, 0, 0, 1,  8'h00, 0, 4'b0000);

    @(negedge clk);
    op_valid    = 1'b0;
    rti_restore = 1'b0;
    int_save    = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_ccr.md
Name: ex_alu_ccr

Overview:
- Execute-stage ALU with condition-code register (CCR) and registered EX/MEM result. Directly downstream of the ALU-B operand select mux.
- Consumes op_a (ra) and op_b (the selected operand: rb, imm/in or ra) plus a 4-bit ALU op from ID/EX.
- Produces a 1-cycle-latency result and flags for the MEM/WB stage and the branch unit.
- Holds a shadow CCR for interrupt entry and return.

Parameters:
- DW, 8, datapath width.
- OPW, 4, ALU opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  ID/EX slot holds a real instruction.
- alu_op  in  OPW  operation code (see package).
- op_a  in  DW  first operand (ra).
- op_b  in  DW  second operand (ALU-B mux output).
- stall  in  1  hold all state this cycle.
- flush  in  1  kill the incoming slot (insert bubble).
- int_save  in  1  interrupt entry: snapshot CCR to shadow.
- rti_restore  in  1  interrupt return: CCR <= shadow.
- alu_result  out  DW  registered result.
- result_valid  out  1  registered valid.
- ccr  out  4  registered flags {V,C,N,Z} (bit3..bit0).

Behaviour:
- Reset (rst_n=0 at a clk edge) clears alu_result=0, result_valid=0, ccr=0 and shadow=0. Reset dominates every other input, including mid-operation.
- Latency is 1 cycle. The result and flags of an op accepted at edge k are visible after edge k.
- An op is accepted when op_valid=1, stall=0 and flush=0.
- Priority per edge: reset > flush > stall > normal.
  - flush: result_valid<=0, alu_result holds, CCR unchanged. int_save and rti_restore are still honoured.
  - stall: alu_result, result_valid, ccr and shadow all hold. int_save and rti_restore are ignored; the controller must hold them.
- Opcodes and flag effects:
  - ADD: a+b, 9-bit sum; C=sum[8]; V=(a7==b7)&&(r7!=a7); updates ZNCV.
  - SUB: a-b; C=1 when a<b unsigned (borrow); V=(a7!=b7)&&(r7!=a7); updates ZNCV.
  - INC: b+1. DEC: b-1. NEG: 0-b. All update ZNCV with ADD/SUB carry/overflow rules.
  - AND, OR: a op b; update Z,N only.
  - NOT: ~b; updates Z,N only.
  - RLC: {C_new, r} = {b, C_old}. RRC: {r, C_new} = {C_old, b}. Both update C, Z, N; V holds.
  - SETC/CLRC: C<=1/0; other flags hold; result = b.
  - MOV: result = b, no flags. NOP: result = 0, no flags, result_valid<=1.
  - Undefined codes behave as NOP.
- Z = (r==0); N = r[DW-1], computed on the DW-bit result only.
- Wrap-around:
  - ADD 0xFF+0x01 gives 0x00, Z=1, C=1, V=0.
  - INC 0x7F gives 0x80, V=1, N=1.
  - DEC 0x00 gives 0xFF, C=1.
- An op not accepted (op_valid=0, not stalled) gives result_valid<=0, CCR unchanged.
- int_save in the same cycle as an accepted flag-writing op: shadow receives the post-op CCR value.
- rti_restore in the same cycle as an accepted flag-writing op: restore wins, CCR<=shadow, and the op's result is still written.
- int_save and rti_restore together: restore CCR from the old shadow, and load shadow with the post-op CCR.
- Back-to-back ops: the next op's RLC/RRC and carry-in read the registered CCR, which already contains the previous op's flags.

Decomposition:
- Shared package holds:
  - ALU opcode localparams: NOP=0, ADD=1, SUB=2, AND=3, OR=4, NOT=5, NEG=6, INC=7, DEC=8, RLC=9, RRC=10, SETC=11, CLRC=12, MOV=13.
  - CCR bit indices Z=0, N=1, C=2, V=3.
  - ALU-B select codes shared with the operand mux.
- One combinational sub-module, alu_core: opcode, a, b and carry_in in; result, next flags and a 4-bit flag write mask out.
- This top holds only registers, priority logic and the shadow.

Test Plan:
- Reset: drive ADD 0x12+0x34 with rst_n=0 -> after edge alu_result=0x00, result_valid=0, ccr=0x0; release -> next ADD gives 0x46, ccr=0x0.
- Overflow/carry: ADD 0x7F+0x01 -> 0x80, ccr {V,C,N,Z}=1010; ADD 0xFF+0x01 -> 0x00, ccr=0101; SUB 0x03-0x05 -> 0xFE, ccr=0110.
- Rotate chain: SETC, then RLC b=0x80 -> 0x01, C=1; RRC b=0x01 -> 0x80, C=1, N=1.
- Stall/flush: ADD then stall 3 cycles -> result and ccr frozen; stall and flush together -> result_valid=0, ccr unchanged.
- Interrupt: ccr=0101, int_save with an accepted AND producing 0x0F -> shadow=0100 (post-op); CLRC; rti_restore concurrent with SETC -> ccr=0100 (restore wins).
- Undefined op 0xF with op_valid=1 -> result 0x00, result_valid=1, ccr unchanged.
